// File: rtl/ps2_kb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kb_fifo
// Description : PS/2 keyboard receiver with prefix folding and a
//               first-word-fall-through event FIFO.
//               The raw SCLK/SDATA pins are synchronised. Each frame is
//               framed and validated. E0/F0 prefixes are folded into the
//               next scan code. Key events queue behind a VALID/READY
//               handshake.
// Config      : define PS2_PARITY_EN to also reject frames with bad odd
//               parity. Without it, the parity bit is shifted but ignored.
// Parameters  : DEPTH        FIFO entries (power of two, >= 2)
//               SYNC_STAGES  synchroniser flops on SCLK/SDATA (>= 2)
//               TIMEOUT_CYC  idle clk cycles that abort a partial frame
// Ports       : i_clk        system clock, rising edge
//               i_arst_l     asynchronous active-low reset
//               i_sclk       raw PS/2 clock pin
//               i_sdata      raw PS/2 data pin
//               i_ready      consumer takes the head entry this cycle
//               o_valid      FIFO non-empty
//               o_keycode    head entry scan code
//               o_keyup      head entry is a break code
//               o_ext        head entry is an extended code
//               o_count      entries held
//               o_overflow   sticky: an event was dropped while full
//               o_frame_err  one-cycle pulse: a frame was rejected
// Revision    : 1.0  initial release
// ============================================================================
module ps2_kb_fifo #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                       i_clk,
  input  logic                       i_arst_l,
  input  logic                       i_sclk,
  input  logic                       i_sdata,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [7:0]                 o_keycode,
  output logic                       o_keyup,
  output logic                       o_ext,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic                       o_frame_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [TW-1:0] C_TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    C_EXT  = 8'hE0;
  localparam logic [7:0]    C_BRK  = 8'hF0;

  // --------------------------------------------------------------------------
  // Pin synchronisers. These reset to the idle-high bus level so that
  // releasing reset cannot create a false falling edge.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic                   r_sclk_prev;
  logic                   w_sclk_s;
  logic                   w_sdata_s;
  logic                   w_fall;

  always_ff @(posedge i_clk or negedge i_arst_l) begin
    if (!i_arst_l) begin
      r_sclk_sync  <= '1;
      r_sdata_sync <= '1;
      r_sclk_prev  <= 1'b1;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], i_sdata};
      r_sclk_prev  <= w_sclk_s;
    end
  end

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdata_s = r_sdata_sync[SYNC_STAGES-1];
  assign w_fall    = r_sclk_prev & ~w_sclk_s;

  // --------------------------------------------------------------------------
  // Frame receiver FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_bitcnt;
  logic [9:0]      r_shift;   // {stop, parity, data[7:0]} after the last shift
  logic [TW-1:0]   r_tcnt;
  logic            r_frame_err;
  logic            r_ext_f;
  logic            r_brk_f;
  logic            w_frame_ok;
  logic            w_prefix;
  logic            w_push;
  logic [9:0]      w_entry;

`ifdef PS2_PARITY_EN
  assign w_frame_ok = r_shift[9] & (^r_shift[8:0]);
`else
  assign w_frame_ok = r_shift[9];
  logic w_unused_par;
  assign w_unused_par = r_shift[8];
`endif

  assign w_prefix = (r_shift[7:0] == C_EXT) | (r_shift[7:0] == C_BRK);
  assign w_push   = (r_state == S_CHECK) & w_frame_ok & ~w_prefix;
  assign w_entry  = {r_ext_f, r_brk_f, r_shift[7:0]};

  always_ff @(posedge i_clk or negedge i_arst_l) begin
    if (!i_arst_l) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 4'd0;
      r_shift     <= 10'd0;
      r_tcnt      <= '0;
      r_frame_err <= 1'b0;
      r_ext_f     <= 1'b0;
      r_brk_f     <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tcnt <= '0;
          // A high data sample on a fall is a glitch, not a start bit.
          if (w_fall && !w_sdata_s) begin
            r_state  <= S_SHIFT;
            r_bitcnt <= 4'd0;
          end
        end
        S_SHIFT: begin
          if (w_fall) begin
            r_shift <= {w_sdata_s, r_shift[9:1]};
            r_tcnt  <= '0;
            if (r_bitcnt == 4'd9) begin
              r_state <= S_CHECK;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end else if (r_tcnt == C_TMAX) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_frame_err <= 1'b1;
            r_ext_f     <= 1'b0;
            r_brk_f     <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_CHECK: begin
          r_state <= S_IDLE;
          if (!w_frame_ok) begin
            r_frame_err <= 1'b1;
            r_ext_f     <= 1'b0;
            r_brk_f     <= 1'b0;
          end else if (r_shift[7:0] == C_EXT) begin
            r_ext_f <= 1'b1;
          end else if (r_shift[7:0] == C_BRK) begin
            r_brk_f <= 1'b1;
          end else begin
            // Prefixes are consumed even if the FIFO drops this event.
            r_ext_f <= 1'b0;
            r_brk_f <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // --------------------------------------------------------------------------
  logic [9:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_valid;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic [9:0]    w_head;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & i_ready;
  assign w_full  = (r_count == C_FULL);
  // A pop in the same cycle frees the slot, so a push at full still succeeds.
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_l) begin
    if (!i_arst_l) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // The head is masked while empty so that the outputs read zero after reset.
  assign w_head      = r_mem[r_rptr];
  assign o_valid     = w_valid;
  assign o_keycode   = w_valid ? w_head[7:0] : 8'd0;
  assign o_keyup     = w_valid & w_head[8];
  assign o_ext       = w_valid & w_head[9];
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kb_fifo
// Description : Directed self-checking bench for ps2_kb_fifo. It drives
//               PS/2 frames bit by bit and checks the decoded FIFO entries
//               against hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_kb_fifo;

  localparam int DEPTH = 8;
  localparam int TO    = 300;

  logic       clk    = 1'b0;
  logic       arst_l = 1'b0;
  logic       sclk   = 1'b1;
  logic       sdata  = 1'b1;
  logic       ready  = 1'b0;
  logic       valid;
  logic [7:0] keycode;
  logic       keyup;
  logic       ext;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;

  int n_vec    = 0;
  int n_err    = 0;
  int ferr_cnt = 0;
  int ferr_ref = 0;

  ps2_kb_fifo #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk       (clk),
    .i_arst_l    (arst_l),
    .i_sclk      (sclk),
    .i_sdata     (sdata),
    .i_ready     (ready),
    .o_valid     (valid),
    .o_keycode   (keycode),
    .o_keyup     (keyup),
    .o_ext       (ext),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive b[0..n-1] LSB first, one SCLK low pulse per bit.
  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) sdata = b[i];
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      repeat (8) @(negedge clk);
      sclk = 1'b1;
    end
    repeat (4) @(negedge clk);
    sdata = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    send_bits({1'b1, p, d, 1'b0}, 11);
  endtask

  // Correct odd parity: the parity bit makes the total number of ones odd.
  task automatic send_key(input logic [7:0] d);
    send_frame(d, ~^d);
  endtask

  task automatic pop_one();
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_keycode", keycode, 0);
    arst_l = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single make code, then pop
    send_key(8'h1C);
    chk("t1_valid", valid, 1);
    chk("t1_keycode", keycode, 8'h1C);
    chk("t1_keyup", keyup, 0);
    chk("t1_ext", ext, 0);
    chk("t1_count", count, 1);
    pop_one();
    chk("t1_pop_valid", valid, 0);
    chk("t1_pop_count", count, 0);

    // 2: prefix folding
    send_key(8'hF0);
    chk("t2_f0_count", count, 0);
    send_key(8'h1C);
    chk("t2_count1", count, 1);
    chk("t2_keycode", keycode, 8'h1C);
    chk("t2_keyup", keyup, 1);
    chk("t2_ext", ext, 0);
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h75);
    chk("t2_count2", count, 2);
    pop_one();
    chk("t2b_keycode", keycode, 8'h75);
    chk("t2b_keyup", keyup, 1);
    chk("t2b_ext", ext, 1);
    pop_one();
    chk("t2_empty", count, 0);

    // 3: frame 0x1C with parity bit 1 (wrong parity)
    ferr_ref = ferr_cnt;
    send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_EN
    chk("t3_ferr", ferr_cnt - ferr_ref, 1);
    chk("t3_count", count, 0);
`else
    chk("t3_ferr", ferr_cnt - ferr_ref, 0);
    chk("t3_count", count, 1);
    chk("t3_keycode", keycode, 8'h1C);
    pop_one();
`endif
    send_key(8'h1C);
    chk("t3_good_count", count, 1);
    chk("t3_good_keycode", keycode, 8'h1C);
    chk("t3_good_keyup", keyup, 0);
    pop_one();

    // 4: overflow with 9 make codes into an 8-entry FIFO
    for (int k = 1; k <= 9; k++) send_key(8'(k));
    chk("t4_count", count, DEPTH);
    chk("t4_ovf", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t4_drain%0d", k), keycode, k);
      pop_one();
    end
    chk("t4_empty", valid, 0);
    chk("t4_ovf_sticky", overflow, 1);

    // 5: partial frame (start + 4 data bits), then SCLK idle past timeout
    ferr_ref = ferr_cnt;
    send_bits(11'b000_0000_1010, 5);
    repeat (TO + 50) @(negedge clk);
    chk("t5_ferr", ferr_cnt - ferr_ref, 1);
    chk("t5_count", count, 0);
    send_key(8'h29);
    chk("t5_count1", count, 1);
    chk("t5_keycode", keycode, 8'h29);
    pop_one();

    // 6: asynchronous reset mid-frame with three entries held
    send_key(8'h11);
    send_key(8'h12);
    send_key(8'h13);
    chk("t6_count3", count, 3);
    send_bits(11'b000_0001_0100, 4);
    @(negedge clk) sclk = 1'b0;
    #2 arst_l = 1'b0;
    #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_keycode", keycode, 0);
    chk("t6_rst_ferr", frame_err, 0);
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    arst_l = 1'b1;
    repeat (4) @(negedge clk);
    send_key(8'h1C);
    chk("t6_count1", count, 1);
    chk("t6_keycode", keycode, 8'h1C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
